// File: rtl/adler32_pkg.sv
// Shared Adler-32 constants, FSM encoding and modular add.
// Used by both the checker and the generator.
package adler32_pkg;

    localparam int DATA_WD         = 32;
    localparam int ADLER32_HALF_WD = 16;
    localparam logic [ADLER32_HALF_WD:0] MOD_BASE = 17'd65521;

    typedef logic [ADLER32_HALF_WD-1:0] half_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACTV,
        ST_B2,
        ST_B3,
        ST_B4,
        ST_WCHK,
        ST_DONE
    } state_t;

    // Both operands are below MOD_BASE, so one subtract is enough.
    function automatic half_t mod_add(input half_t a, input half_t b);
        logic [ADLER32_HALF_WD:0] t;
        t = {1'b0, a} + {1'b0, b};
        if (t >= MOD_BASE) begin
            t = t - MOD_BASE;
        end
        return t[ADLER32_HALF_WD-1:0];
    endfunction

endpackage

// File: rtl/adler32_byte_upd.sv
// Combinational Adler-32 single-byte update of s1/s2.
// Shared between checker and generator.
import adler32_pkg::*;

module adler32_byte_upd (
    input  logic [7:0] b,
    input  half_t      s1,
    input  half_t      s2,
    output half_t      s1_nxt,
    output half_t      s2_nxt
);

    assign s1_nxt = mod_add(s1, {8'h00, b});
    assign s2_nxt = mod_add(s2, s1_nxt);

endmodule

// File: rtl/adler32_chk.sv
// Adler-32 checker for the inflate output: one byte per cycle,
// compares against the zlib trailer and reports pass/fail.
import adler32_pkg::*;

module adler32_chk (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start_i,
    input  logic               val_i,
    output logic               rdy_o,
    input  logic [DATA_WD-1:0] dat_i,
    input  logic               lst_i,
    input  logic [1:0]         len_i,
    input  logic               chk_val_i,
    input  logic [DATA_WD-1:0] chk_dat_i,
    output logic               done_o,
    output logic               pass_o,
    output logic [DATA_WD-1:0] dat_o
);

    state_t      state;
    half_t       s1;
    half_t       s2;
    half_t       s1_nxt;
    half_t       s2_nxt;
    logic [23:0] word_q;
    logic        lst_q;
    logic [1:0]  len_q;
    logic        rdy_q;
    logic        done_q;
    logic        pass_q;
    logic [7:0]  cur_b;
    logic        hs;
    logic        upd;

    assign hs  = (state == ST_ACTV) && val_i;
    assign upd = hs || (state == ST_B2) ||
                 (state == ST_B3) || (state == ST_B4);

    always_comb begin
        cur_b = dat_i[31:24];
        unique case (1'b1)
            (state == ST_B2): cur_b = word_q[23:16];
            (state == ST_B3): cur_b = word_q[15:8];
            (state == ST_B4): cur_b = word_q[7:0];
            default:          cur_b = dat_i[31:24];
        endcase
    end

    adler32_byte_upd u_upd (
        .b      (cur_b),
        .s1     (s1),
        .s2     (s2),
        .s1_nxt (s1_nxt),
        .s2_nxt (s2_nxt)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= ST_IDLE;
            s1     <= '0;
            s2     <= '0;
            word_q <= '0;
            lst_q  <= 1'b0;
            len_q  <= 2'd0;
            rdy_q  <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (upd) begin
                s1 <= s1_nxt;
                s2 <= s2_nxt;
            end
            unique case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        s1     <= half_t'(1);
                        s2     <= '0;
                        pass_q <= 1'b0;
                        rdy_q  <= 1'b1;
                        state  <= ST_ACTV;
                    end
                end
                ST_ACTV: begin
                    if (val_i) begin
                        word_q <= dat_i[23:0];
                        lst_q  <= lst_i;
                        len_q  <= len_i;
                        rdy_q  <= 1'b0;
                        if (lst_i && (len_i == 2'd1)) begin
                            state <= ST_WCHK;
                        end else begin
                            state <= ST_B2;
                        end
                    end
                end
                ST_B2: begin
                    if (lst_q && (len_q == 2'd2)) begin
                        state <= ST_WCHK;
                    end else begin
                        state <= ST_B3;
                    end
                end
                ST_B3: begin
                    if (lst_q && (len_q == 2'd3)) begin
                        state <= ST_WCHK;
                    end else begin
                        state <= ST_B4;
                    end
                end
                ST_B4: begin
                    if (lst_q) begin
                        state <= ST_WCHK;
                    end else begin
                        rdy_q <= 1'b1;
                        state <= ST_ACTV;
                    end
                end
                ST_WCHK: begin
                    if (chk_val_i) begin
                        pass_q <= (chk_dat_i == {s2, s1});
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rdy_o  = rdy_q;
    assign done_o = done_q;
    assign pass_o = pass_q;
    assign dat_o  = {s2, s1};

endmodule
